// File: rtl/cpu_clock_pkg.sv
// Shared types and constants for the 6502 clock generator.
package cpu_clock_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  localparam int DIV_MIN       = 2;
  localparam int CNT_W_DEFAULT = 28;

endpackage

// File: rtl/cpu_clock_step_in.sv
// Step pushbutton input: two-flop synchroniser, optional debounce, rising-edge pulse.
// Optional debounce is enabled by defining CPU_CLOCK_GEN_STEP_DEBOUNCE_EN.
module cpu_clock_step_in #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic step_i,
  output logic step_req_o
);

  logic sync1_q;
  logic sync2_q;
  logic lvl_prev_q;
  logic req_q;
  logic lvl;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      sync1_q    <= step_i;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
      req_q      <= lvl & ~lvl_prev_q;
    end
  end

`ifdef CPU_CLOCK_GEN_STEP_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q;
  logic            db_lvl_q;

  // The counter only runs while the synchronised pin disagrees with the accepted level.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
    end else if (sync2_q == db_lvl_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_lvl_q <= sync2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign lvl = db_lvl_q;
`else
  assign lvl = sync2_q;
`endif

  assign step_req_o = req_q;

endmodule

// File: rtl/cpu_clock_gen.sv
// Programmable 6502 clock divider with run/halt, single-step and period-aligned divisor reload.
// Build option: CPU_CLOCK_GEN_STEP_DEBOUNCE_EN adds a debounce filter on step_i.
//
// state | meaning
// HALT  | counter parked at 0, clk_out low, divisor writes applied immediately
// RUN   | free-running periods; leaves at a wrap when run_i is low
// STEP  | exactly one period, then back to HALT
module cpu_clock_gen
  import cpu_clock_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int DIV_DEFAULT     = 200000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             step_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             halted
);

  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] DIV_FLOOR = CNT_W'(DIV_MIN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             rise_q, fall_q;

  logic [CNT_W-1:0] eff_div;
  logic [CNT_W-1:0] half_div;
  logic [CNT_W-1:0] cnt_inc;
  logic             wrap;
  logic             step_req;

  cpu_clock_step_in #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_in (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .step_i    (step_i),
    .step_req_o(step_req)
  );

  assign eff_div  = (act_q < DIV_FLOOR) ? DIV_FLOOR : act_q;
  assign half_div = eff_div >> 1;
  assign cnt_inc  = cnt_q + 1'b1;
  assign wrap     = (cnt_q == eff_div - 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pdiv_d  = pdiv_q;
    pend_d  = pend_q;
    clk_d   = 1'b0;

    case (state_q)
      HALT: begin
        cnt_d = '0;
        if (pend_q) begin
          act_d  = pdiv_q;
          pend_d = 1'b0;
        end
        // A fresh period starts high: the effective divisor is at least 2.
        if (run_i) begin
          state_d = RUN;
          clk_d   = 1'b1;
        end else if (step_req) begin
          state_d = STEP;
          clk_d   = 1'b1;
        end
      end
      RUN, STEP: begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_q) begin
            act_d  = pdiv_q;
            pend_d = 1'b0;
          end
          if (state_q == RUN && run_i) begin
            clk_d = 1'b1;
          end else begin
            state_d = HALT;
          end
        end else begin
          cnt_d = cnt_inc;
          clk_d = (cnt_inc < half_div);
        end
      end
      default: begin
        state_d = HALT;
        cnt_d   = '0;
      end
    endcase

    if (div_valid && !pend_q) begin
      pend_d = 1'b1;
      pdiv_d = div_i;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HALT;
      cnt_q   <= '0;
      act_q   <= DIV_RST;
      pdiv_q  <= '0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      rise_q  <= clk_d & ~clk_q;
      fall_q  <= ~clk_d & clk_q;
    end
  end

  assign clk_out   = clk_q;
  assign rise_stb  = rise_q;
  assign fall_stb  = fall_q;
  assign halted    = (state_q == HALT);
  assign div_ready = ~pend_q;

endmodule

// File: doc/cpu_clock_gen.md
Name: cpu_clock_gen

Overview:
- Parametrised, run-time programmable clock divider that produces the 6502 core clock from the board clock.
- Adds run/halt control, single-step for debugging, and glitch-free divisor reload at period boundaries.
- Emits rise/fall strobes so downstream logic can stay in the clk_in domain instead of clocking off clk_out.

Parameters:
- CNT_W, 28, width of the period counter and divisor.
- DIV_DEFAULT, 200000, divisor in force after reset; must be >= 2.
- DEBOUNCE_CYCLES, 1000000, stable cycles required on step_i; used only with the optional feature.

Ports:
- clk_in  input  1  board clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run_i  input  1  level: 1 = free-run, 0 = halt at the next period end.
- step_i  input  1  asynchronous pushbutton; a rising edge requests one period while halted.
- div_i  input  CNT_W  new divisor value.
- div_valid  input  1  div_i is valid.
- div_ready  output  1  block can accept a divisor.
- clk_out  output  1  divided clock.
- rise_stb  output  1  one-cycle pulse in the first clk_in cycle clk_out is high.
- fall_stb  output  1  one-cycle pulse in the first clk_in cycle clk_out is low after a high phase.
- halted  output  1  block is in HALT.

Behaviour:
- Reset values (async): counter=0, active divisor=DIV_DEFAULT, no pending divisor, state=HALT, clk_out=0, rise_stb=0, fall_stb=0, halted=1, div_ready=1, step synchroniser cleared.
- Divisor:
  - Effective divisor D = max(active divisor, 2), so divisor values 0 and 1 are treated as 2.
  - Each period is D cycles: clk_out high for floor(D/2) cycles, then low for D-floor(D/2) cycles.
  - counter runs 0..D-1 and wraps to 0.
- States: HALT, RUN, STEP.
- HALT:
  - counter held at 0; clk_out=0; halted=1.
  - run_i=1 -> RUN. clk_out rises in the cycle after the transition.
  - Synchronised step_i rising edge with run_i=0 -> STEP.
  - If run_i=1 and a step edge occur in the same cycle, run_i wins.
- RUN:
  - counter free-runs.
  - At wrap (counter=D-1) with run_i=0 -> HALT, so the last period always completes.
  - run_i deasserting mid-period never truncates a pulse.
- STEP:
  - Exactly one full period is produced, then -> HALT at wrap, even if run_i rose during the step.
  - RUN is entered from HALT on the following cycle.
  - Step edges seen in RUN or STEP are discarded, not queued.
- Strobes:
  - rise_stb and fall_stb are registered and coincident with the clk_out transition they mark.
  - They are never both high in the same cycle.
  - They are never asserted in HALT.
- Divisor handshake:
  - Transfer occurs when div_valid && div_ready. The value is latched as pending and div_ready drops the next cycle.
  - Pending divisor becomes active at the next wrap in RUN/STEP, or on the next cycle in HALT.
  - div_ready returns to 1 the cycle after the pending divisor is applied.
  - A period already in progress always completes with the old divisor, so no runt pulses.
- step_i path: two-flop synchroniser, then rising-edge detector; latency 3 cycles from pin to request.
- Reset mid-period: clk_out drops to 0 immediately (async); a pending divisor is lost.

Optional Feature:
- Macro: CPU_CLOCK_GEN_STEP_DEBOUNCE_EN.
- When defined: the synchronised step_i must be stable for DEBOUNCE_CYCLES consecutive cycles before its level is accepted; edge detection runs on the debounced level.
  - Debounce counter width is derived from DEBOUNCE_CYCLES via $clog2.
  - The debounce counter resets to 0 on any level change and on rst_n.
- When undefined: no debounce; edge detection runs on the raw synchroniser output, and the DEBOUNCE_CYCLES parameter is ignored.

Decomposition:
- Shared package cpu_clock_pkg:
  - state enum {HALT, RUN, STEP}.
  - DIV_MIN = 2.
  - Default CNT_W constant.
- Sub-module cpu_clock_step_in:
  - Contains the synchroniser, the optional debounce and the edge detector.
  - Output is a single-cycle step_req.
- Top level holds the FSM, counter, divisor registers and strobes.

Test Plan:
- Reset, run_i=1, divisor set to 4 while halted -> clk_out repeats 1,1,0,0; rise_stb every 4th cycle; fall_stb 2 cycles after each rise.
- Divisor 5, then 0 -> high 2 / low 3; then divisor 0 gives high 1 / low 1 (clamped to 2).
- RUN with D=6, write divisor 10 mid-high-phase -> current period completes as 3H/3L; next period is 5H/5L; div_ready low from the cycle after the handshake until the cycle after the wrap.
- HALT, pulse step_i (no debounce) -> one rise_stb 4 cycles after the pin edge; exactly one full period; halted returns to 1; a second step_i during STEP produces no extra period.
- RUN D=8, drop run_i at counter=1 -> high phase finishes, low phase finishes, then HALT with clk_out=0 and no further strobes.
- Assert rst_n=0 asynchronously while clk_out=1 -> clk_out, strobes and div_ready take reset values in the same cycle; after release, halted=1 and the active divisor is DIV_DEFAULT.
